wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Write-back stage plus architectural register file of the pipelined MIPS core.
//   Unpacks the 71-bit MEM/WB bundle and selects write data: ALU result or load data.
//   Commits the write into a 32x32 register file and serves the two ID-stage read ports.
//   Exports the WB write (en/addr/data) for the forwarding unit and keeps a retire counter.
// PARAMETERS
//   NREG  32  number of architectural registers (index 0 hardwired to zero)
//   DW    32  data width
//   AW    5   register address width, log2(NREG)
//   CW    32  retire counter width
// PORTS
//   clk         in   1    clock, rising-edge
//   clr         in   1    reset, asynchronous, active-high
//   wb_bus      in   71   MEM/WB bundle: [0]RegWrite [1]MemToReg [6:2]writeReg [38:7]alu_out [70:39]dmOut
//   ra1         in   AW   read address, port 1 (rs)
//   ra2         in   AW   read address, port 2 (rt)
//   rd1         out  DW   read data, port 1
//   rd2         out  DW   read data, port 2
//   wb_en_o     out  1    effective write enable this cycle (RegWrite && writeReg!=0)
//   wb_addr_o   out  AW   write address this cycle
//   wb_data_o   out  DW   selected write data this cycle
//   retire_cnt  out  CW   count of committed register writes
// BEHAVIOUR
//   - Write data: wb_data_o = MemToReg ? dmOut : alu_out; combinational from wb_bus.
//   - wb_en_o = RegWrite & (writeReg != 0); wb_addr_o = writeReg; all combinational, no latency.
//   - Commit: on posedge clk with wb_en_o=1, regs[writeReg] <= wb_data_o. One write per cycle.
//   - Register 0: never stored; any read of address 0 returns 0 regardless of writes.
//   - Reads: rd1/rd2 combinational from regs[ra1]/regs[ra2]; both ports may read same address.
//   - retire_cnt: +1 on each posedge clk with wb_en_o=1; saturates at all-ones (no wrap).
//   - Writes with RegWrite=1 to address 0 do not count and do not change state.
//   - Reset: clr=1 asynchronously clears regs[1..NREG-1] and retire_cnt to 0; while clr=1,
//     rd1=rd2=0 and no commit occurs; a bundle present when clr deasserts commits on next edge.
//   - wb_bus with RegWrite=0 (bubble/flush, all-zero bundle) -> no state change, wb_en_o=0.
//   - X on unused bundle fields (alu_out/dmOut when RegWrite=0) must not propagate to state.
// CONFIGURATION
//   WB_BYPASS_EN defined: same-cycle write-to-read bypass; if wb_en_o=1 and raN==wb_addr_o
//     (raN!=0), rdN = wb_data_o instead of stored value (ID sees the value committing now).
//   WB_BYPASS_EN undefined: rdN = stored value only; ID reading the register being written
//     this cycle gets the old value; hazard unit must stall one cycle or forward externally.
//   retire_cnt, wb_*_o and commit timing identical in both builds.
// STRUCTURE
//   Shared package cpu_pkg: bundle field constants WB_RW_BIT=0, WB_M2R_BIT=1,
//     WB_WA_LSB=2/MSB=6, WB_ALU_LSB=7/MSB=38, WB_DM_LSB=39/MSB=70, WB_BUS_W=71,
//     plus REG_ZERO=5'd0. Same constants used by the MEM/WB register producing the bundle.
//   One sub-module: regfile_2r1w (storage array, async clear, 2 comb read, 1 sync write,
//     zero-register rule). Top holds bundle unpack, write mux, bypass, retire counter.
// TESTING
//   1 Reset: pulse clr mid-cycle after writes -> rd1/rd2 for ra=1..31 all 0, retire_cnt=0 immediately.
//   2 ALU write: RegWrite=1 MemToReg=0 writeReg=5 alu_out=32'h1234_5678 -> after edge rd1(ra1=5)=32'h1234_5678, retire_cnt=1.
//   3 Load write: RegWrite=1 MemToReg=1 writeReg=9 dmOut=32'hDEAD_BEEF alu_out=32'h0 -> regs[9]=32'hDEAD_BEEF.
//   4 Zero reg: RegWrite=1 writeReg=0 alu_out=32'hFFFF_FFFF -> rd1(ra1=0)=0, wb_en_o=0, retire_cnt unchanged.
//   5 Same-cycle read: regs[7]=1, write 7<=2, ra2=7 -> rd2=2 with WB_BYPASS_EN, rd2=1 without; both 2 after edge.
//   6 Saturation: force retire_cnt=32'hFFFF_FFFE, three writes -> 32'hFFFF_FFFF, holds.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: MEM/WB bundle bit layout shared by the MEM/WB pipeline register and wb_regfile.
// The layout is LSB first: RegWrite, MemToReg, writeReg, alu_out, dmOut.
package cpu_pkg;

   localparam int WB_RW_BIT  = 0;
   localparam int WB_M2R_BIT = 1;
   localparam int WB_WA_LSB  = 2;
   localparam int WB_WA_MSB  = 6;
   localparam int WB_ALU_LSB = 7;
   localparam int WB_ALU_MSB = 38;
   localparam int WB_DM_LSB  = 39;
   localparam int WB_DM_MSB  = 70;
   localparam int WB_BUS_W   = 71;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [31:0] dm_out;
      logic [31:0] alu_out;
      logic [4:0]  write_reg;
      logic        mem_to_reg;
      logic        reg_write;
   } wb_fields_t;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB bundle in, ID read ports, forwarding export and retire count.
// The master side is the pipeline (MEM/WB register plus ID stage); the slave side is wb_regfile.
interface wb_regfile_if
   import cpu_pkg::*;
#(
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int CW = 32
)();

   logic [WB_BUS_W-1:0] wb_bus;
   logic [AW-1:0]       ra1;
   logic [AW-1:0]       ra2;
   logic [DW-1:0]       rd1;
   logic [DW-1:0]       rd2;
   logic                wb_en_o;
   logic [AW-1:0]       wb_addr_o;
   logic [DW-1:0]       wb_data_o;
   logic [CW-1:0]       retire_cnt;

   modport master (
      output wb_bus, ra1, ra2,
      input  rd1, rd2, wb_en_o, wb_addr_o, wb_data_o, retire_cnt
   );

   modport slave (
      input  wb_bus, ra1, ra2,
      output rd1, rd2, wb_en_o, wb_addr_o, wb_data_o, retire_cnt
   );

endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: architectural register storage, two combinational reads, one clocked write.
// Register 0 has no storage; it always reads as zero and writes to it are dropped.
module regfile_2r1w
   import cpu_pkg::*;
#(
   parameter int NREG = 32,
   parameter int DW   = 32,
   parameter int AW   = 5
)(
   input  logic          clk,
   input  logic          clr,
   input  logic          we_i,
   input  logic [AW-1:0] wa_i,
   input  logic [DW-1:0] wd_i,
   input  logic [AW-1:0] ra1_i,
   input  logic [AW-1:0] ra2_i,
   output logic [DW-1:0] rd1_o,
   output logic [DW-1:0] rd2_o
);

   // Asynchronous clear of the whole array rules out block RAM; it maps to flops.
   logic [DW-1:0] regs_q [1:NREG-1];
   logic [AW-1:0] ra_a   [2];
   logic [DW-1:0] rd_a   [2];

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (wa_i != REG_ZERO)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign ra_a[0] = ra1_i;
   assign ra_a[1] = ra2_i;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_read
         assign rd_a[gi] = (ra_a[gi] == REG_ZERO) ? '0 : regs_q[ra_a[gi]];
      end
   endgenerate

   assign rd1_o = rd_a[0];
   assign rd2_o = rd_a[1];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage, 32x32 register file, forwarding export, retire counter.
// Define WB_BYPASS_EN to let ID reads see the value being committed in the same cycle.
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int NREG = 32,
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int CW   = 32
)(
   input logic         clk,
   input logic         clr,
   wb_regfile_if.slave bus
);

   wb_fields_t    wb_f;
   logic          wb_en;
   logic [DW-1:0] wb_data;
   logic [AW-1:0] ra_a [2];
   logic [DW-1:0] st_a [2];
   logic [DW-1:0] rd_a [2];
   logic [CW-1:0] retire_q;
   logic [CW-1:0] retire_d;

   always_comb begin
      wb_f.reg_write  = bus.wb_bus[WB_RW_BIT];
      wb_f.mem_to_reg = bus.wb_bus[WB_M2R_BIT];
      wb_f.write_reg  = bus.wb_bus[WB_WA_MSB:WB_WA_LSB];
      wb_f.alu_out    = bus.wb_bus[WB_ALU_MSB:WB_ALU_LSB];
      wb_f.dm_out     = bus.wb_bus[WB_DM_MSB:WB_DM_LSB];
   end

   // Gating on writeReg keeps bubbles and $zero writes invisible to forwarding and the counter.
   assign wb_en   = wb_f.reg_write && (wb_f.write_reg != REG_ZERO);
   assign wb_data = wb_f.mem_to_reg ? wb_f.dm_out : wb_f.alu_out;

   regfile_2r1w #(
      .NREG (NREG),
      .DW   (DW),
      .AW   (AW)
   ) u_regfile (
      .clk   (clk),
      .clr   (clr),
      .we_i  (wb_en),
      .wa_i  (wb_f.write_reg),
      .wd_i  (wb_data),
      .ra1_i (bus.ra1),
      .ra2_i (bus.ra2),
      .rd1_o (st_a[0]),
      .rd2_o (st_a[1])
   );

   assign ra_a[0] = bus.ra1;
   assign ra_a[1] = bus.ra2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef WB_BYPASS_EN
         // wb_en already excludes address 0, so a matching read address is never 0 here.
         assign rd_a[gi] = (!clr && wb_en && (ra_a[gi] == wb_f.write_reg)) ? wb_data : st_a[gi];
`else
         assign rd_a[gi] = st_a[gi];
`endif
      end
   endgenerate

   always_comb begin
      retire_d = retire_q;
      if (wb_en && (retire_q != '1)) begin
         retire_d = retire_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         retire_q <= '0;
      end else begin
         retire_q <= retire_d;
      end
   end

   assign bus.rd1        = rd_a[0];
   assign bus.rd2        = rd_a[1];
   assign bus.wb_en_o    = wb_en;
   assign bus.wb_addr_o  = wb_f.write_reg;
   assign bus.wb_data_o  = wb_data;
   assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector table, hand sequences and random traffic vs a register-array model.
// A second instance with a 2-bit retire counter exercises saturation.
module tb_wb_regfile;

   logic clk = 1'b0;
   logic clr;

   always #5 clk = ~clk;

   wb_regfile_if #(.AW(5), .DW(32), .CW(32)) bus ();
   wb_regfile_if #(.AW(5), .DW(32), .CW(2))  sbus ();

   wb_regfile #(.NREG(32), .DW(32), .AW(5), .CW(32)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   wb_regfile #(.NREG(32), .DW(32), .AW(5), .CW(2)) dut_sat (
      .clk (clk),
      .clr (clr),
      .bus (sbus.slave)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   typedef struct {
      bit          rw;
      bit          m2r;
      logic [4:0]  wa;
      logic [31:0] alu;
      logic [31:0] dm;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      bit          x_en;
      logic [31:0] x_data;
      logic [31:0] x_rd1;
      logic [31:0] x_rd2;
      logic [31:0] x_cnt;
   } vec_t;

   vec_t vt [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [70:0] mk(input bit rw, input bit m2r, input logic [4:0] wa,
                                      input logic [31:0] alu, input logic [31:0] dm);
      return {dm, alu, wa, m2r, rw};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] ra, input bit en,
                                          input logic [4:0] wa, input logic [31:0] wd);
      if (ra == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
      if (en && ra == wa) return wd;
`endif
      return m_regs[ra];
   endfunction

   task automatic m_commit(input bit en, input logic [4:0] wa, input logic [31:0] wd);
      if (en) begin
         m_regs[wa] = wd;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
   endtask

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 32'h0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0]  r_wa;
      logic [4:0]  r_ra1;
      logic [4:0]  r_ra2;
      logic [31:0] r_alu;
      logic [31:0] r_dm;
      logic [31:0] r_wd;
      bit          r_rw;
      bit          r_m2r;
      bit          r_en;
      logic [31:0] exp_same;

      vt[0] = '{1'b1, 1'b0, 5'd5,  32'h1234_5678, 32'h0,         5'd5,  5'd0, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0,         32'd1};
      vt[1] = '{1'b1, 1'b1, 5'd9,  32'h0,         32'hDEAD_BEEF, 5'd9,  5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678, 32'd2};
      vt[2] = '{1'b1, 1'b0, 5'd0,  32'hFFFF_FFFF, 32'h0,         5'd0,  5'd9, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'hDEAD_BEEF, 32'd2};
      vt[3] = '{1'b0, 1'b0, 5'd5,  32'hAAAA_AAAA, 32'h5555_5555, 5'd5,  5'd9, 1'b0, 32'hAAAA_AAAA, 32'h1234_5678, 32'hDEAD_BEEF, 32'd2};
      vt[4] = '{1'b1, 1'b0, 5'd7,  32'h1,         32'h0,         5'd7,  5'd7, 1'b1, 32'h1,         32'h1,         32'h1,         32'd3};
      vt[5] = '{1'b1, 1'b1, 5'd31, 32'h1111_1111, 32'hCAFE_F00D, 5'd31, 5'd5, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h1234_5678, 32'd4};

      m_clear();
      clr         = 1'b1;
      bus.wb_bus  = '0;
      bus.ra1     = 5'd1;
      bus.ra2     = 5'd31;
      sbus.wb_bus = '0;
      sbus.ra1    = 5'd0;
      sbus.ra2    = 5'd0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_cnt", bus.retire_cnt, 32'h0);
      chk("reset_rd1", bus.rd1, 32'h0);
      chk("reset_rd2", bus.rd2, 32'h0);
      clr = 1'b0;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.wb_bus = mk(vt[i].rw, vt[i].m2r, vt[i].wa, vt[i].alu, vt[i].dm);
         bus.ra1    = vt[i].ra1;
         bus.ra2    = vt[i].ra2;
         #1;
         chk($sformatf("vec%0d_en", i),   32'(bus.wb_en_o), 32'(vt[i].x_en));
         chk($sformatf("vec%0d_addr", i), 32'(bus.wb_addr_o), 32'(vt[i].wa));
         chk($sformatf("vec%0d_data", i), bus.wb_data_o, vt[i].x_data);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_rd1", i), bus.rd1, vt[i].x_rd1);
         chk($sformatf("vec%0d_rd2", i), bus.rd2, vt[i].x_rd2);
         chk($sformatf("vec%0d_cnt", i), bus.retire_cnt, vt[i].x_cnt);
         m_commit(vt[i].x_en, vt[i].wa, vt[i].x_data);
      end

      // Same-cycle read of the register being written (regs[7] holds 1)
      @(negedge clk);
      bus.wb_bus = mk(1'b1, 1'b0, 5'd7, 32'h2, 32'h0);
      bus.ra1    = 5'd9;
      bus.ra2    = 5'd7;
`ifdef WB_BYPASS_EN
      exp_same = 32'h2;
`else
      exp_same = 32'h1;
`endif
      #1;
      chk("same_cycle_rd2", bus.rd2, exp_same);
      chk("same_cycle_rd1", bus.rd1, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      chk("after_edge_rd2", bus.rd2, 32'h2);
      chk("after_edge_cnt", bus.retire_cnt, 32'd5);
      m_commit(1'b1, 5'd7, 32'h2);

      // Random traffic against the model
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         r_rw  = ($urandom_range(0, 3) != 0);
         r_m2r = $urandom_range(0, 1) != 0;
         r_wa  = 5'($urandom_range(0, 31));
         r_alu = $urandom;
         r_dm  = $urandom;
         r_ra1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
         r_ra2 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
         r_en  = r_rw && (r_wa != 5'd0);
         r_wd  = r_m2r ? r_dm : r_alu;
         bus.wb_bus = mk(r_rw, r_m2r, r_wa, r_alu, r_dm);
         bus.ra1    = r_ra1;
         bus.ra2    = r_ra2;
         #1;
         chk($sformatf("rnd%0d_en", n),   32'(bus.wb_en_o), 32'(r_en));
         chk($sformatf("rnd%0d_data", n), bus.wb_data_o, r_wd);
         chk($sformatf("rnd%0d_rd1", n),  bus.rd1, m_read(r_ra1, r_en, r_wa, r_wd));
         chk($sformatf("rnd%0d_rd2", n),  bus.rd2, m_read(r_ra2, r_en, r_wa, r_wd));
         @(posedge clk);
         m_commit(r_en, r_wa, r_wd);
         #1;
         chk($sformatf("rnd%0d_cnt", n), bus.retire_cnt, m_cnt);
      end

      // Mid-cycle asynchronous reset pulse
      @(negedge clk);
      bus.wb_bus = '0;
      bus.ra1    = 5'd5;
      bus.ra2    = 5'd9;
      #1;
      clr = 1'b1;
      #1;
      chk("clr_cnt_now", bus.retire_cnt, 32'h0);
      chk("clr_rd1_now", bus.rd1, 32'h0);
      chk("clr_rd2_now", bus.rd2, 32'h0);
      #1;
      clr = 1'b0;
      m_clear();
      for (int ra = 1; ra < 32; ra++) begin
         bus.ra1 = 5'(ra);
         bus.ra2 = 5'(32 - ra);
         #1;
         chk($sformatf("clr_rd1_r%0d", ra), bus.rd1, 32'h0);
         chk($sformatf("clr_rd2_r%0d", 32 - ra), bus.rd2, 32'h0);
      end

      // Bundle held through reset commits on the first edge after release
      @(negedge clk);
      bus.wb_bus = mk(1'b1, 1'b0, 5'd3, 32'h0000_0033, 32'h0);
      bus.ra1    = 5'd3;
      clr        = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_clr_cnt", bus.retire_cnt, 32'h0);
      chk("hold_clr_rd1", bus.rd1, 32'h0);
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("release_cnt", bus.retire_cnt, 32'h0);
      @(posedge clk);
      #1;
      chk("release_commit_rd1", bus.rd1, 32'h0000_0033);
      chk("release_commit_cnt", bus.retire_cnt, 32'd1);
      @(negedge clk);
      bus.wb_bus = '0;

      // Saturation on the 2-bit counter instance
      chk("sat_start", 32'(sbus.retire_cnt), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         sbus.wb_bus = mk(1'b1, 1'b0, 5'd1, 32'(k), 32'h0);
         @(posedge clk);
         #1;
         chk($sformatf("sat_w%0d", k), 32'(sbus.retire_cnt), (k < 3) ? 32'(k) : 32'd3);
      end
      @(negedge clk);
      sbus.wb_bus = '0;
      @(posedge clk);
      #1;
      chk("sat_hold", 32'(sbus.retire_cnt), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
